// File: rtl/bcd_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared types and helpers for the sequential binary-to-BCD converter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Number of decimal digits needed for the largest WIDTH-bit unsigned value
  function automatic int min_digits(input int width);
    longint unsigned v;
    int n;
    v = (longint'(1) << width) - 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        n = n + 1;
        v = v / 10;
      end
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_add3_digit.sv
// ============================================================================
// Module  : bcd_add3_digit
// Brief   : Combinational double-dabble correction cell (x >= 5 ? x + 3 : x)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module  : bin_to_bcd_seq
// Brief   : Sequential shift-add-3 binary to packed BCD with leading-zero blanking
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int c_bcdw = 4 * DIGITS;
  localparam int c_sw   = c_bcdw + WIDTH;
  localparam int c_cw   = $clog2(WIDTH + 1);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be in 4..32");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  state_t              r_state, w_state_nxt;
  logic [c_sw-1:0]     r_scratch, w_scratch_nxt, w_corr, w_shift;
  logic [c_cw-1:0]     r_count, w_count_nxt;
  logic [c_bcdw-1:0]   r_bcd, w_bcd_nxt, w_blanked;
  logic                r_done, w_done_nxt;
  logic                w_seen;

  // BCD field sits above the binary field; every nibble is corrected in parallel
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_add3_digit u_add3 (
      .din  (r_scratch[WIDTH + 4*d +: 4]),
      .dout (w_corr[WIDTH + 4*d +: 4])
    );
  end
  assign w_corr[WIDTH-1:0] = r_scratch[WIDTH-1:0];
  assign w_shift           = w_corr << 1;

  // Digit 0 is excluded from the scan so a zero value still shows "0"
  always_comb begin
    w_blanked = w_shift[c_sw-1:WIDTH];
    w_seen    = 1'b0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (w_blanked[4*d +: 4] != 4'd0) begin
        w_seen = 1'b1;
      end else if (!w_seen && (BLANK_LZ != 0)) begin
        w_blanked[4*d +: 4] = BCD_BLANK;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_scratch_nxt = r_scratch;
    w_count_nxt   = r_count;
    w_bcd_nxt     = r_bcd;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_scratch_nxt = {{c_bcdw{1'b0}}, bin_in};
          w_count_nxt   = c_cw'(WIDTH);
          w_state_nxt   = CONVERT;
        end
      end
      CONVERT: begin
        w_scratch_nxt = w_shift;
        w_count_nxt   = r_count - c_cw'(1);
        if (r_count == c_cw'(1)) begin
          w_bcd_nxt   = w_blanked;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_scratch <= '0;
      r_count   <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_scratch <= w_scratch_nxt;
      r_count   <= w_count_nxt;
      r_bcd     <= w_bcd_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign busy    = (r_state == CONVERT);
  assign done    = r_done;
  assign bcd_out = r_bcd;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// ============================================================================
// Module  : tb_bin_to_bcd_seq
// Brief   : Scoreboard bench for bin_to_bcd_seq, blanking and plain variants
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin_in = '0;
  logic        busy_b, done_b, busy_p, done_p;
  logic [19:0] bcd_b, bcd_p;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int busyc   = 0;

  typedef struct {
    logic [19:0] eb;
    logic [19:0] ep;
    int          cyc;
  } exp_t;
  exp_t q[$];

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(0)) dut_p (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy_p), .done(done_p), .bcd_out(bcd_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busyc = 0;
    end else begin
      if (busy_b) busyc++;
      if (done_b || done_p) begin
        chk("done_sync", {31'd0, done_p}, {31'd0, done_b});
        if (q.size() == 0) begin
          chk("stray_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("bcd_blank", {12'd0, bcd_b}, {12'd0, e.eb});
          chk("bcd_plain", {12'd0, bcd_p}, {12'd0, e.ep});
          chk("latency", cyc, e.cyc);
          chk("busy_len", busyc, 32'd16);
        end
        busyc = 0;
      end
    end
  end

  task automatic launch(input logic [15:0] v, input logic [19:0] eb, input logic [19:0] ep);
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    e.eb = eb; e.ep = ep; e.cyc = cyc + 16;
    q.push_back(e);
    start = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge clk);
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 32'd0);
      q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    exp_t e;
    #1;
    chk("rst_busy", {31'd0, busy_b}, 32'd0);
    chk("rst_done", {31'd0, done_b}, 32'd0);
    chk("rst_bcd_b", {12'd0, bcd_b}, 32'd0);
    chk("rst_bcd_p", {12'd0, bcd_p}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed single conversions
    launch(16'd0,     20'hFFFF0, 20'h00000); drain();
    launch(16'd65535, 20'h65535, 20'h65535); drain();
    launch(16'd1234,  20'hF1234, 20'h01234); drain();
    launch(16'd9,     20'hFFFF9, 20'h00009); drain();
    launch(16'd10000, 20'h10000, 20'h10000); drain();
    launch(16'd100,   20'hFF100, 20'h00100); drain();
    chk("hold_bcd", {12'd0, bcd_b}, 32'h000FF100);

    // Starts and bin_in changes during a run are ignored
    launch(16'd500, 20'hFF500, 20'h00500);
    bin_in = 16'd4321;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; bin_in = 16'd123;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 start = 1'b1; bin_in = 16'd77;
    @(posedge clk);
    #1 start = 1'b0; bin_in = 16'd0;
    drain();

    // Start held high: back-to-back conversions
    @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd42;
    @(posedge clk);
    #1;
    e.eb = 20'hFFF42; e.ep = 20'h00042; e.cyc = cyc + 16; q.push_back(e);
    e.eb = 20'hFFFF7; e.ep = 20'h00007; e.cyc = cyc + 33; q.push_back(e);
    bin_in = 16'd7;
    repeat (17) @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_busy", {31'd0, busy_b}, 32'd1);
    drain();

    // Reset mid-conversion aborts asynchronously
    @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd999;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy_b}, 32'd0);
    chk("abort_done", {31'd0, done_b}, 32'd0);
    chk("abort_bcd_b", {12'd0, bcd_b}, 32'd0);
    chk("abort_bcd_p", {12'd0, bcd_p}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    chk("post_abort_busy", {31'd0, busy_b}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
